pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage MIPS pipeline around the main control decoder. Detects load-use hazards,

---
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage MIPS pipeline: load-use stalls, branch/jump flushes,
// data-memory wait freeze with sticky timeout error, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             id_jump_i,
   input  logic             ex_mem_read_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             ex_br_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ready_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_freeze_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic {RUN, MEM_WAIT} state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              memw;
   logic              lu;

   assign memw = dmem_req_i & ~dmem_ready_i;
   assign lu   = ex_mem_read_i & (ex_rt_i != 5'd0) &
                 ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

   // Priority: memory wait > taken branch > load-use > jump
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      if (!rst_n) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (memw) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         pipe_freeze_o = 1'b1;
      end else if (ex_br_taken_i) begin
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
      end else if (lu) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (id_jump_i) begin
         ifid_flush_o  = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      case (state_q)
         RUN:      if (memw) state_d = MEM_WAIT;
         MEM_WAIT: if (!dmem_req_i || dmem_ready_i) state_d = RUN;
         default:  state_d = RUN;
      endcase
      // The entering cycle counts as the first wait cycle
      if (state_d == MEM_WAIT)
         wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_ONE;
      mem_err_d = mem_err_q | (wait_cnt_d == WAIT_MAX);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_o && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (ifid_flush_o && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_err_o   = mem_err_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// expected responses queued by the driver and compared by an independent monitor.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
   logic             id_uses_rt = 0, id_jump = 0, ex_mem_read = 0, ex_br_taken = 0;
   logic             dmem_req = 0, dmem_ready = 0;
   logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt), .id_jump_i(id_jump),
      .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt), .ex_br_taken_i(ex_br_taken),
      .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
      .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
      .idex_bubble_o(idex_bubble), .pipe_freeze_o(pipe_freeze), .mem_err_o(mem_err),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      logic  pc, ifw, fl, bub, frz, err;
      int    sc, fc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: plain integers
   int  m_stall = 0, m_flush = 0, m_run = 0;
   bit  m_err = 0;

   task automatic chk(input string name, input string tag, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, act, expv);
      end
   endtask

   task automatic step(input string tag, input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                       input bit ut, input bit jp, input bit mr, input logic [4:0] er,
                       input bit br, input bit rq, input bit rd);
      exp_t e;
      bit   memw, lu;
      @(posedge clk);
      #1;
      rst_n = ~rst; id_rs = rs; id_rt = rt; id_uses_rt = ut; id_jump = jp;
      ex_mem_read = mr; ex_rt = er; ex_br_taken = br; dmem_req = rq; dmem_ready = rd;
      if (rst) begin
         m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
      end
      memw = rq && !rd;
      lu   = mr && er != 0 && (er == rs || (ut && er == rt));
      e.tag = tag;
      e.pc = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.frz = 0;
      if (rst)       begin e.pc = 0; e.ifw = 0; e.bub = 1; end
      else if (memw) begin e.pc = 0; e.ifw = 0; e.frz = 1; end
      else if (br)   begin e.fl = 1; e.bub = 1; end
      else if (lu)   begin e.pc = 0; e.ifw = 0; e.bub = 1; end
      else if (jp)   e.fl = 1;
      e.err = m_err; e.sc = m_stall; e.fc = m_flush;
      q.push_back(e);
      if (!rst) begin
         if (!e.pc) m_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
         if (e.fl)  m_flush = (m_flush + 1 > CNT_MAX) ? CNT_MAX : m_flush + 1;
         m_run = memw ? m_run + 1 : 0;
         if (m_run >= MEM_TIMEOUT) m_err = 1;
      end
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("pc_write",    e.tag, int'(pc_write),    int'(e.pc));
            chk("ifid_write",  e.tag, int'(ifid_write),  int'(e.ifw));
            chk("ifid_flush",  e.tag, int'(ifid_flush),  int'(e.fl));
            chk("idex_bubble", e.tag, int'(idex_bubble), int'(e.bub));
            chk("pipe_freeze", e.tag, int'(pipe_freeze), int'(e.frz));
            chk("mem_err",     e.tag, int'(mem_err),     int'(e.err));
            chk("stall_cnt",   e.tag, int'(stall_cnt),   e.sc);
            chk("flush_cnt",   e.tag, int'(flush_cnt),   e.fc);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      // Reset state
      step("reset0", 1, 5'd8, 5'd8, 1, 1, 1, 5'd8, 1, 1, 0);
      step("reset1", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
      idle("idle0");
      // lw $t0 in EX, add rs=$t0 in ID: one-cycle stall
      step("lu_rs", 0, 5'd8, 5'd9, 1, 0, 1, 5'd8, 0, 0, 0);
      step("after_lu", 0, 5'd8, 5'd9, 1, 0, 0, 5'd0, 0, 0, 0);
      // lw $zero never stalls
      step("lu_zero", 0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0);
      // rt match counts only when rt is read
      step("sw_rt", 0, 5'd3, 5'd9, 1, 0, 1, 5'd9, 0, 0, 0);
      step("no_uses_rt", 0, 5'd3, 5'd9, 0, 0, 1, 5'd9, 0, 0, 0);
      // Branch beats load-use and jump
      step("br_lu_jp", 0, 5'd8, 5'd8, 1, 1, 1, 5'd8, 1, 0, 0);
      step("lu_jp", 0, 5'd8, 5'd8, 1, 1, 1, 5'd8, 0, 0, 0);
      step("jump", 0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, 0, 0);
      // Three wait cycles then ready; memw beats a simultaneous branch
      step("memw1", 0, 5'd8, 5'd8, 1, 1, 1, 5'd8, 1, 1, 0);
      step("memw2", 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
      step("memw3", 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
      step("mem_rdy", 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 1);
      idle("idle1");
      // Timeout after four wait cycles, sticky thereafter
      for (int i = 0; i < 6; i++) step($sformatf("tmo%0d", i), 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
      step("tmo_rdy", 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 1);
      idle("tmo_sticky");
      // Reset in the middle of a wait clears error and wait progress
      step("mw_a", 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
      step("mw_b", 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
      step("mw_rst", 1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step($sformatf("post_rst%0d", i), 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 0);
      step("post_rst_rdy", 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0);
      // Saturation of both counters
      for (int i = 0; i < CNT_MAX + 3; i++) step($sformatf("sat_st%0d", i), 0, 5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 0);
      for (int i = 0; i < CNT_MAX + 3; i++) step($sformatf("sat_fl%0d", i), 0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, 0, 0);
      idle("sat_hold");
      step("sat_rst", 1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0);
      // Random traffic over a small register space to provoke hazards
      for (int i = 0; i < 400; i++) begin
         step($sformatf("rnd%0d", i), ($urandom_range(0, 99) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      end
      idle("final");
      @(posedge clk);
      @(negedge clk);
      #2;
      chk("scoreboard_drained", "end", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
